// File: rtl/board_writer_pkg.sv
// Shared types and constants for the playfield writer: geometry, score limits,
// FSM state encoding and the cell-index helper.
package board_writer_pkg;

  localparam int unsigned BoardCols = 8;
  localparam int unsigned BoardRows = 16;
  localparam int unsigned ScoreW    = 10;
  localparam int unsigned MapW      = BoardCols * BoardRows;

  localparam logic [ScoreW-1:0] ScoreMax = 10'd99;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StMerge = 3'd1,
    StScan  = 3'd2,
    StShift = 3'd3,
    StDone  = 3'd4
  } state_e;

  // Bit position of cell (x, y) in the map: y*8 + x.
  function automatic logic [6:0] idx(input logic [2:0] x, input logic [3:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/board_writer_if.sv
// Lock request, piece coordinates and playfield/score outputs of board_writer.
interface board_writer_if;

  logic                                 lock_req;
  logic [2:0]                           b1_x, b2_x, b3_x, b4_x;
  logic [3:0]                           b1_y, b2_y, b3_y, b4_y;
  logic [board_writer_pkg::MapW-1:0]    map;
  logic                                 busy;
  logic                                 done;
  logic [board_writer_pkg::ScoreW-1:0]  row;
  logic                                 game_over;

  modport master (
    output lock_req, b1_x, b2_x, b3_x, b4_x, b1_y, b2_y, b3_y, b4_y,
    input  map, busy, done, row, game_over
  );

  modport slave (
    input  lock_req, b1_x, b2_x, b3_x, b4_x, b1_y, b2_y, b3_y, b4_y,
    output map, busy, done, row, game_over
  );

endinterface

// File: rtl/board_row_shift.sv
// Combinational removal of row r: rows r..1 take rows r-1..0, row 0 becomes empty.
module board_row_shift
  import board_writer_pkg::*;
(
  input  logic [MapW-1:0] cur,
  input  logic [3:0]      r,
  output logic [MapW-1:0] shifted
);

  always_comb begin
    shifted = '0;
    for (int j = 1; j < int'(BoardRows); j++) begin
      if (j > int'(r)) begin
        shifted[j*8 +: 8] = cur[j*8 +: 8];
      end else begin
        shifted[j*8 +: 8] = cur[(j-1)*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/board_writer.sv
// Single writer of the 8x16 playfield: merges locked pieces, clears full rows, counts lines.
// Optional sticky game-over detection is enabled by defining BOARD_GAMEOVER_EN.
module board_writer
  import board_writer_pkg::*;
(
  input  logic          CLK,
  input  logic          reset,
  board_writer_if.slave bus
);

  state_e            state_q;
  logic [MapW-1:0]   map_q;
  logic [3:0]        r_q;
  logic [6:0]        cell_q [4];
  logic [ScoreW-1:0] row_q;
  logic              busy_q;
  logic              done_q;
  logic              game_over_q;

  logic [MapW-1:0]   piece;
  logic [MapW-1:0]   shifted;
  logic              row_full;
  logic              accept;

  always_comb begin
    piece = '0;
    for (int i = 0; i < 4; i++) begin
      piece[cell_q[i]] = 1'b1;
    end
  end

  assign row_full = (map_q[{r_q, 3'b000} +: 8] == 8'hFF);

`ifdef BOARD_GAMEOVER_EN
  assign accept = bus.lock_req && !game_over_q;
`else
  assign accept = bus.lock_req;
`endif

  board_row_shift u_row_shift (
    .cur     (map_q),
    .r       (r_q),
    .shifted (shifted)
  );

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q     <= StIdle;
      map_q       <= '0;
      r_q         <= '0;
      row_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      game_over_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cell_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            cell_q[0] <= idx(bus.b1_x, bus.b1_y);
            cell_q[1] <= idx(bus.b2_x, bus.b2_y);
            cell_q[2] <= idx(bus.b3_x, bus.b3_y);
            cell_q[3] <= idx(bus.b4_x, bus.b4_y);
            busy_q    <= 1'b1;
            state_q   <= StMerge;
          end
        end
        StMerge: begin
          map_q   <= map_q | piece;
          r_q     <= 4'd15;
          state_q <= StScan;
`ifdef BOARD_GAMEOVER_EN
          if (|(map_q & piece)) begin
            game_over_q <= 1'b1;
          end
`endif
        end
        StScan: begin
          if (row_full) begin
            state_q <= StShift;
          end else if (r_q == 4'd0) begin
            busy_q  <= 1'b0;
            state_q <= StDone;
          end else begin
            r_q <= r_q - 4'd1;
          end
        end
        StShift: begin
          // r stays put so the row that just moved down gets re-checked.
          map_q   <= shifted;
          state_q <= StScan;
          if (row_q < ScoreMax) begin
            row_q <= row_q + ScoreW'(1);
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
`ifdef BOARD_GAMEOVER_EN
          if (|map_q[7:0]) begin
            game_over_q <= 1'b1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.map       = map_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.row       = row_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_board_writer.sv
// Directed self-checking bench for board_writer: merge, row clearing, shifting,
// score saturation, mid-operation reset and (with BOARD_GAMEOVER_EN) game over.
module tb_board_writer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_pass = 0;
  int   n_checks = 0;

  always #5 clk = ~clk;

  board_writer_if bus ();

  board_writer dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Drives one lock request; lat = edges from acceptance to the done pulse (60 = timed out).
  task automatic do_lock(input logic [2:0] x1, input logic [3:0] y1,
                         input logic [2:0] x2, input logic [3:0] y2,
                         input logic [2:0] x3, input logic [3:0] y3,
                         input logic [2:0] x4, input logic [3:0] y4,
                         output int lat, output logic busy_seen);
    @(negedge clk);
    bus.b1_x = x1; bus.b1_y = y1; bus.b2_x = x2; bus.b2_y = y2;
    bus.b3_x = x3; bus.b3_y = y3; bus.b4_x = x4; bus.b4_y = y4;
    bus.lock_req = 1'b1;
    @(posedge clk); #1;
    bus.lock_req = 1'b0;
    busy_seen = bus.busy;
    lat = 0;
    while (!bus.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.lock_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.map !== '0) $display("FAIL reset_map got %h want 0", bus.map); else n_pass++;
    n_checks++; if (bus.row !== '0) $display("FAIL reset_row got %0d want 0", bus.row); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.game_over !== 1'b0) $display("FAIL reset_go got %b want 0", bus.game_over); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_piece();
    int lat; logic bs;
    logic [127:0] exp_map;
    exp_map = 128'h0F << 120;
    do_lock(0, 15, 1, 15, 2, 15, 3, 15, lat, bs);
    n_checks++; if (bs !== 1'b1) $display("FAIL single_busy got %b want 1", bs); else n_pass++;
    n_checks++; if (lat != 18) $display("FAIL single_latency got %0d want 18", lat); else n_pass++;
    n_checks++; if (bus.map !== exp_map) $display("FAIL single_map got %h want %h", bus.map, exp_map); else n_pass++;
    n_checks++; if (bus.row !== 10'd0) $display("FAIL single_row got %0d want 0", bus.row); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL single_busy_done got %b want 0", bus.busy); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL single_done_pulse got %b want 0", bus.done); else n_pass++;
  endtask

  task automatic test_bottom_clear();
    int lat; logic bs;
    do_lock(4, 15, 5, 15, 6, 15, 7, 15, lat, bs);
    n_checks++; if (lat != 20) $display("FAIL bottom_latency got %0d want 20", lat); else n_pass++;
    n_checks++; if (bus.map !== '0) $display("FAIL bottom_map got %h want 0", bus.map); else n_pass++;
    n_checks++; if (bus.row !== 10'd1) $display("FAIL bottom_row got %0d want 1", bus.row); else n_pass++;
  endtask

  task automatic test_four_lines();
    int lat; logic bs;
    for (int y = 12; y < 16; y++) begin
      do_lock(0, 4'(y), 1, 4'(y), 2, 4'(y), 3, 4'(y), lat, bs);
      do_lock(4, 4'(y), 5, 4'(y), 6, 4'(y), 6, 4'(y), lat, bs);
    end
    n_checks++; if (bus.row !== 10'd1) $display("FAIL four_pre_row got %0d want 1", bus.row); else n_pass++;
    do_lock(7, 12, 7, 13, 7, 14, 7, 15, lat, bs);
    n_checks++; if (lat != 26) $display("FAIL four_latency got %0d want 26", lat); else n_pass++;
    n_checks++; if (bus.map !== '0) $display("FAIL four_map got %h want 0", bus.map); else n_pass++;
    n_checks++; if (bus.row !== 10'd5) $display("FAIL four_row got %0d want 5", bus.row); else n_pass++;
  endtask

  task automatic test_shift_down();
    int lat; logic bs;
    logic [127:0] exp_map;
    exp_map = 128'h1 << 120;
    for (int y = 14; y < 16; y++) begin
      do_lock(0, 4'(y), 1, 4'(y), 2, 4'(y), 3, 4'(y), lat, bs);
      do_lock(4, 4'(y), 5, 4'(y), 6, 4'(y), 6, 4'(y), lat, bs);
    end
    do_lock(0, 13, 0, 13, 0, 13, 0, 13, lat, bs);
    do_lock(7, 14, 7, 15, 7, 14, 7, 15, lat, bs);
    n_checks++; if (lat != 22) $display("FAIL shift_latency got %0d want 22", lat); else n_pass++;
    n_checks++; if (bus.map !== exp_map) $display("FAIL shift_marker got %h want %h", bus.map, exp_map); else n_pass++;
    n_checks++; if (bus.row !== 10'd7) $display("FAIL shift_row got %0d want 7", bus.row); else n_pass++;
  endtask

  task automatic test_saturation();
    int lat; logic bs;
    do_lock(1, 15, 2, 15, 3, 15, 4, 15, lat, bs);
    do_lock(5, 15, 6, 15, 7, 15, 7, 15, lat, bs);
    n_checks++; if (bus.row !== 10'd8) $display("FAIL sat_row8 got %0d want 8", bus.row); else n_pass++;
    for (int k = 0; k < 90; k++) begin
      do_lock(0, 15, 1, 15, 2, 15, 3, 15, lat, bs);
      do_lock(4, 15, 5, 15, 6, 15, 7, 15, lat, bs);
    end
    n_checks++; if (bus.row !== 10'd98) $display("FAIL sat_row98 got %0d want 98", bus.row); else n_pass++;
    for (int y = 14; y < 16; y++) begin
      do_lock(0, 4'(y), 1, 4'(y), 2, 4'(y), 3, 4'(y), lat, bs);
      do_lock(4, 4'(y), 5, 4'(y), 6, 4'(y), 6, 4'(y), lat, bs);
    end
    do_lock(7, 14, 7, 15, 7, 14, 7, 15, lat, bs);
    n_checks++; if (bus.row !== 10'd99) $display("FAIL sat_row99 got %0d want 99", bus.row); else n_pass++;
    n_checks++; if (bus.map !== '0) $display("FAIL sat_map got %h want 0", bus.map); else n_pass++;
    do_lock(0, 15, 1, 15, 2, 15, 3, 15, lat, bs);
    do_lock(4, 15, 5, 15, 6, 15, 7, 15, lat, bs);
    n_checks++; if (lat != 20) $display("FAIL sat_hold_latency got %0d want 20", lat); else n_pass++;
    n_checks++; if (bus.row !== 10'd99) $display("FAIL sat_hold_row got %0d want 99", bus.row); else n_pass++;
    n_checks++; if (bus.map !== '0) $display("FAIL sat_hold_map got %h want 0", bus.map); else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    int lat; logic bs; int seen_done;
    do_lock(0, 15, 1, 15, 2, 15, 3, 15, lat, bs);
    @(negedge clk);
    bus.b1_x = 4; bus.b1_y = 15; bus.b2_x = 5; bus.b2_y = 15;
    bus.b3_x = 6; bus.b3_y = 15; bus.b4_x = 7; bus.b4_y = 15;
    bus.lock_req = 1'b1;
    @(posedge clk); #1;  // accepted
    bus.lock_req = 1'b0;
    @(posedge clk); #1;  // merged
    @(posedge clk); #1;  // scan found row 15 full, now in SHIFT
    n_checks++; if (bus.map !== {8'hFF, 120'h0}) $display("FAIL mid_premap got %h want full row 15", bus.map); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL mid_busy got %b want 1", bus.busy); else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.map !== '0) $display("FAIL mid_map got %h want 0", bus.map); else n_pass++;
    n_checks++; if (bus.row !== '0) $display("FAIL mid_row got %0d want 0", bus.row); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL mid_busy_after got %b want 0", bus.busy); else n_pass++;
    reset = 1'b1;
    seen_done = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.done) seen_done++;
    end
    n_checks++; if (seen_done != 0) $display("FAIL mid_no_done got %0d pulses want 0", seen_done); else n_pass++;
  endtask

  task automatic test_game_over();
    int lat; logic bs;
    do_lock(2, 10, 2, 10, 2, 10, 2, 10, lat, bs);
    do_lock(2, 10, 3, 10, 3, 10, 3, 10, lat, bs);
    n_checks++; if (lat != 18) $display("FAIL go_latency got %0d want 18", lat); else n_pass++;
`ifdef BOARD_GAMEOVER_EN
    n_checks++; if (bus.game_over !== 1'b1) $display("FAIL go_flag got %b want 1", bus.game_over); else n_pass++;
    do_lock(5, 5, 5, 5, 5, 5, 5, 5, lat, bs);
    n_checks++; if (bs !== 1'b0) $display("FAIL go_ignored_busy got %b want 0", bs); else n_pass++;
    n_checks++; if (lat != 60) $display("FAIL go_ignored_done got %0d want timeout 60", lat); else n_pass++;
`else
    n_checks++; if (bus.game_over !== 1'b0) $display("FAIL go_tied got %b want 0", bus.game_over); else n_pass++;
    do_lock(5, 5, 5, 5, 5, 5, 5, 5, lat, bs);
    n_checks++; if (bs !== 1'b1) $display("FAIL go_accept_busy got %b want 1", bs); else n_pass++;
`endif
  endtask

  initial begin
    bus.lock_req = 1'b0;
    bus.b1_x = '0; bus.b2_x = '0; bus.b3_x = '0; bus.b4_x = '0;
    bus.b1_y = '0; bus.b2_y = '0; bus.b3_y = '0; bus.b4_y = '0;
    test_reset();
    test_single_piece();
    test_bottom_clear();
    test_four_lines();
    test_shift_down();
    test_saturation();
    test_reset_mid_shift();
    test_game_over();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
